router_fsm: RTL and testbench

- Control FSM for the 1x3 router input side. Sits directly upstream of the header/parity datapath register block.
- Decodes the header address and sequences header, payload, after-full and parity loads.
- Drives detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg and busy.
- Consumes parity_done and low_pkt_valid from the datapath, plus fifo_full, fifo_empty and soft_reset from the output side.

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_fsm.sv | 185 ++++++++++++++++++
 tb/tb_router_fsm.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router input-side control FSM.
// Holds the state encoding and the default sizing constants.
package router_pkg;

  localparam int NUM_PORTS_DEF      = 3;
  localparam int ADDR_W_DEF         = 2;
  localparam int TIMEOUT_CYCLES_DEF = 30;

  localparam logic [1:0] INVALID_ADDR = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

endpackage : router_pkg

// File: rtl/router_fsm.sv
// Router input-side control FSM: header decode and header/payload/parity load sequencing.
// Define ROUTER_FSM_WAIT_TIMEOUT_EN to add the WAIT_TILL_EMPTY watchdog and timeout_drop pulse.
//
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for a header with a valid address
// WAIT_TILL_EMPTY    | header seen, selected FIFO still draining
// LOAD_FIRST_DATA    | header byte written into the datapath
// LOAD_DATA          | payload bytes streaming into the FIFO
// FIFO_FULL_STATE    | selected FIFO full, source held off
// LOAD_AFTER_FULL    | resume after full, pick data/parity/done
// LOAD_PARITY        | parity byte written
// CHECK_PARITY_ERROR | datapath compares parity, internal regs reset
module router_fsm
  import router_pkg::*;
#(
  parameter int NUM_PORTS      = NUM_PORTS_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic                 timeout_drop
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;

  logic w_addr_ok;
  logic w_hdr_empty;
  logic w_sel_empty;
  logic w_sel_soft;
  logic w_wait_expire;

  // Out-of-range header addresses never index the empty vector.
  assign w_addr_ok   = (int'(data_in) < NUM_PORTS);
  assign w_hdr_empty = w_addr_ok ? fifo_empty[data_in] : 1'b0;
  assign w_sel_empty = fifo_empty[r_addr];
  assign w_sel_soft  = soft_reset[r_addr];

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_wait_cnt;
  logic       r_timeout_drop;

  // Count is forced to zero outside WAIT_TILL_EMPTY, so every entry starts fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (r_state != WAIT_TILL_EMPTY) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  assign w_wait_expire = (r_state == WAIT_TILL_EMPTY) && (r_wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timeout_drop <= 1'b0;
    end else begin
      r_timeout_drop <= w_wait_expire && !w_sel_empty && !w_sel_soft;
    end
  end

  assign timeout_drop = r_timeout_drop;
`else
  assign w_wait_expire = 1'b0;
  assign timeout_drop  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= DECODE_ADDRESS;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
    end else if ((r_state == DECODE_ADDRESS) && pkt_valid && w_addr_ok) begin
      r_addr <= data_in;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_sel_soft && (r_state != DECODE_ADDRESS)) begin
      w_next = DECODE_ADDRESS;
    end else begin
      case (r_state)
        DECODE_ADDRESS: begin
          if (pkt_valid && w_addr_ok) begin
            w_next = w_hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (w_sel_empty) begin
            w_next = LOAD_FIRST_DATA;
          end else if (w_wait_expire) begin
            w_next = DECODE_ADDRESS;
          end
        end
        LOAD_FIRST_DATA: w_next = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full) begin
            w_next = FIFO_FULL_STATE;
          end else if (!pkt_valid) begin
            w_next = LOAD_PARITY;
          end
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) begin
            w_next = LOAD_AFTER_FULL;
          end
        end
        LOAD_AFTER_FULL: begin
          if (parity_done) begin
            w_next = DECODE_ADDRESS;
          end else if (low_pkt_valid) begin
            w_next = LOAD_PARITY;
          end else begin
            w_next = LOAD_DATA;
          end
        end
        LOAD_PARITY: w_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        default: w_next = DECODE_ADDRESS;
      endcase
    end
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;
    case (r_state)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      LOAD_FIRST_DATA: lfd_state = 1'b1;
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      FIFO_FULL_STATE:    full_state    = 1'b1;
      LOAD_PARITY:        write_enb_reg = 1'b1;
      CHECK_PARITY_ERROR: rst_int_reg   = 1'b1;
      default: ;
    endcase
  end

endmodule : router_fsm

// File: tb/tb_router_fsm.sv
// Directed self-checking bench for router_fsm; output vectors per state are hand-written constants.
module tb_router_fsm;
  import router_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy, timeout_drop;

  int checks   = 0;
  int failures = 0;

  // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy, timeout_drop}
  localparam logic [8:0] O_DA   = 9'b1_0000_0000;
  localparam logic [8:0] O_LFD  = 9'b0_1000_0010;
  localparam logic [8:0] O_LD   = 9'b0_0100_0100;
  localparam logic [8:0] O_LAF  = 9'b0_0010_0110;
  localparam logic [8:0] O_FULL = 9'b0_0001_0010;
  localparam logic [8:0] O_CPE  = 9'b0_0000_1010;
  localparam logic [8:0] O_LP   = 9'b0_0000_0110;
  localparam logic [8:0] O_WTE  = 9'b0_0000_0010;
  localparam logic [8:0] O_DROP = 9'b1_0000_0001;

  logic [8:0] w_outs;
  assign w_outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                   rst_int_reg, write_enb_reg, busy, timeout_drop};

  router_fsm dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy), .timeout_drop(timeout_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step_chk(input string tag, input logic [8:0] exp);
    @(posedge clk);
    #1;
    chk(tag, 32'(w_outs), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;

    step_chk("rst_c1", O_DA);
    step_chk("rst_c2", O_DA);
    reset = 1'b0;
    step_chk("idle", O_DA);

    // Header 0x05 -> addr 1, three payload bytes, then parity
    pkt_valid = 1'b1; data_in = 2'b01;
    step_chk("p1_lfd", O_LFD);
    step_chk("p1_ld1", O_LD);
    step_chk("p1_ld2", O_LD);
    step_chk("p1_ld3", O_LD);
    pkt_valid = 1'b0;
    step_chk("p1_lp", O_LP);
    step_chk("p1_cpe", O_CPE);
    step_chk("p1_da", O_DA);

    // Header addr 2 while FIFO 2 still draining
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
    step_chk("w_enter", O_WTE);
    for (int i = 0; i < 4; i++) step_chk("w_hold", O_WTE);
    fifo_empty = 3'b111;
    step_chk("w_lfd", O_LFD);
    step_chk("w_ld", O_LD);

    // Full handling, LAF -> LP
    fifo_full = 1'b1;
    step_chk("f1_full", O_FULL);
    step_chk("f1_hold", O_FULL);
    fifo_full = 1'b0;
    step_chk("f1_laf", O_LAF);
    low_pkt_valid = 1'b1;
    step_chk("f1_lp", O_LP);
    step_chk("f1_cpe", O_CPE);
    fifo_full = 1'b1; low_pkt_valid = 1'b0;
    step_chk("cpe_full", O_FULL);
    fifo_full = 1'b0;
    step_chk("f2_laf", O_LAF);
    step_chk("f2_ld", O_LD);
    // full wins over pkt_valid falling
    fifo_full = 1'b1; pkt_valid = 1'b0;
    step_chk("f3_full", O_FULL);
    fifo_full = 1'b0;
    step_chk("f3_laf", O_LAF);
    parity_done = 1'b1;
    step_chk("f3_da", O_DA);
    parity_done = 1'b0;

    // Invalid header address
    pkt_valid = 1'b1; data_in = INVALID_ADDR;
    step_chk("bad_addr1", O_DA);
    step_chk("bad_addr2", O_DA);

    // Soft reset: only the selected port counts
    data_in = 2'd0;
    step_chk("s_lfd", O_LFD);
    step_chk("s_ld", O_LD);
    soft_reset = 3'b010;
    step_chk("s_other", O_LD);
    soft_reset = 3'b001;
    pkt_valid = 1'b0;
    step_chk("s_sel", O_DA);
    soft_reset = 3'b000;

    // Soft reset releases WAIT_TILL_EMPTY
    pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b000;
    step_chk("sw_wte", O_WTE);
    pkt_valid = 1'b0; soft_reset = 3'b010;
    step_chk("sw_da", O_DA);
    soft_reset = 3'b000; fifo_empty = 3'b111;

    // Reset mid-packet
    pkt_valid = 1'b1; data_in = 2'd2;
    step_chk("r_lfd", O_LFD);
    step_chk("r_ld", O_LD);
    reset = 1'b1;
    step_chk("r_da", O_DA);
    reset = 1'b0; pkt_valid = 1'b0;
    step_chk("r_idle", O_DA);

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
    step_chk("t_wte", O_WTE);
    pkt_valid = 1'b0;
    for (int i = 0; i < 29; i++) step_chk("t_hold", O_WTE);
    step_chk("t_drop", O_DROP);
    step_chk("t_after", O_DA);
    fifo_empty = 3'b111;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_router_fsm
